// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop and acknowledge.
// Optional PS2_TX_TIMEOUT_EN adds a device-response timeout over the SHIFT and ACK states.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_transmitter: INHIBIT_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [8:0]       sreg_q, sreg_d;
  logic             cur_bit_q, cur_bit_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             dat_meta_q, dat_sync_q;
  logic             clk_oe_d, dat_oe_d, ready_d, busy_d, done_d, err_d;
  logic             clk_fall, timeout;

  assign clk_fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_wait;

  assign in_wait  = (state_q == S_SHIFT) || (state_q == S_ACK);
  assign timeout  = in_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d = in_wait ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) to_cnt_q <= '0;
    else         to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      cur_bit_q  <= 1'b1;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      cur_bit_q  <= cur_bit_d;
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      tx_ready   <= ready_d;
      busy       <= busy_d;
      tx_done    <= done_d;
      tx_error   <= err_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
    end
  end

  // Frame shift register holds {parity, data}; it never gates a line without a valid state.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sreg_d    = sreg_q;
    cur_bit_d = cur_bit_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_INHIBIT;
          sreg_d  = {~^tx_data, tx_data};
          cnt_d   = '0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) state_d = S_REQ;
        else                                     cnt_d   = cnt_q + 1'b1;
      end
      S_REQ: begin
        state_d   = S_SHIFT;
        bit_idx_d = '0;
        cur_bit_d = 1'b0;
      end
      S_SHIFT: begin
        if (timeout) begin
          state_d = S_WAIT_IDLE;
        end else if (clk_fall) begin
          // Ones shift in from the top so the tenth edge presents the stop bit.
          bit_idx_d = bit_idx_q + 1'b1;
          cur_bit_d = sreg_q[0];
          sreg_d    = {1'b1, sreg_q[8:1]};
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout || clk_fall) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that the registered pins line up with it.
  always_comb begin
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    dat_oe_d = (state_d == S_REQ) || ((state_d == S_SHIFT) && !cur_bit_d);
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_ACK) && !timeout && clk_fall && !dat_sync_q;
    err_d    = timeout || ((state_q == S_ACK) && clk_fall && dat_sync_q);
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain bus with a clocking PS/2 device model and frame/result scoreboards.
module tb_ps2_host_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 3000;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic exp_bits[$];
  logic exp_res[$];

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Result scoreboard: every done/error pulse pops the expected outcome (1 = done, 0 = error).
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && (tx_done || tx_error)) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
        check_val("done_err_exclusive", int'(tx_done & tx_error), 0);
        check_val("result_expected", int'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) check_val("result", int'(tx_done), int'(exp_res.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic pop_bit(input string tag);
    check_val("bit_queue_nonempty", int'(exp_bits.size() > 0), 1);
    if (exp_bits.size() > 0) check_val(tag, int'(ps2_dat_in), int'(exp_bits.pop_front()));
  endtask

  task automatic send(input logic [7:0] b, input bit push, input bit ack);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_before_send", int'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) begin
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      exp_bits.push_back(~^b);
      exp_bits.push_back(1'b1);
      exp_res.push_back(ack);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_val("busy_after_accept", int'(busy), 1);
  endtask

  task automatic abort_now();
    check_val("abort_dat_oe_before", int'(ps2_dat_oe), 1);
    resetn = 1'b0;
    #1;
    check_val("abort_clk_oe", int'(ps2_clk_oe), 0);
    check_val("abort_dat_oe", int'(ps2_dat_oe), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_ready", int'(tx_ready), 1);
    dev_clk_low = 1'b0;
    exp_bits.delete();
    exp_res.delete();
    wait_cyc(5);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Device model: waits for request-to-send, clocks 11 falling edges, samples each presented bit.
  task automatic dev_run(input bit ack, input int abort_k);
    int n = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && n < INH * 4 + 100) begin
      @(negedge clk);
      n++;
    end
    check_val("request_seen", int'(ps2_clk_in && !ps2_dat_in), 1);
    if (!(ps2_clk_in && !ps2_dat_in)) return;
    wait_cyc(HALF);
    pop_bit("start_bit");
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      wait_cyc(HALF);
      pop_bit("frame_bit");
      if (k == abort_k) begin
        abort_now();
        return;
      end
      dev_clk_low = 1'b0;
      wait_cyc(HALF);
    end
    dev_dat_low = ack;
    wait_cyc(HALF);
    dev_clk_low = 1'b1;
    wait_cyc(HALF);
    dev_clk_low = 1'b0;
    wait_cyc(2);
    dev_dat_low = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, int'(tx_ready), 1);
  endtask

  initial begin
    int d0, e0, hi, n;
    logic d1, d2;

    wait_cyc(3);
    check_val("rst_ready", int'(tx_ready), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(tx_done), 0);
    check_val("rst_error", int'(tx_error), 0);
    check_val("rst_clk_oe", int'(ps2_clk_oe), 0);
    check_val("rst_dat_oe", int'(ps2_dat_oe), 0);
    @(negedge clk);
    resetn = 1'b1;
    wait_cyc(4);

    // 0xED acknowledged
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 1'b1, 1'b1);
    dev_run(1'b1, 0);
    wait_ready("ed_ready_back");
    check_val("ed_done_count", done_cnt - d0, 1);
    check_val("ed_err_count", err_cnt - e0, 0);

    // 0xF4 with inhibit and request timing
    d0 = done_cnt;
    send(8'hF4, 1'b1, 1'b1);
    hi = 0; d1 = 1'b0; d2 = 1'b0;
    fork
      begin
        for (int i = 0; i < INH * 3; i++) begin
          @(negedge clk);
          if (!ps2_clk_oe) break;
          hi++;
          d2 = d1;
          d1 = ps2_dat_oe;
        end
        check_val("f4_inhibit_len", hi, INH);
        check_val("f4_dat_oe_last_low_cycle", int'(d1), 1);
        check_val("f4_dat_oe_before_req", int'(d2), 0);
        check_val("f4_dat_oe_at_release", int'(ps2_dat_oe), 1);
      end
      dev_run(1'b1, 0);
    join
    wait_ready("f4_ready_back");
    check_val("f4_done_count", done_cnt - d0, 1);

    // Missing acknowledge
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1'b1, 1'b0);
    dev_run(1'b0, 0);
    wait_ready("noack_ready_back");
    check_val("noack_err_count", err_cnt - e0, 1);
    check_val("noack_done_count", done_cnt - d0, 0);

    // tx_valid while busy is ignored
    d0 = done_cnt;
    send(8'hA3, 1'b1, 1'b1);
    fork
      dev_run(1'b1, 0);
      begin
        wait_cyc(INH + 60);
        check_val("busy_ready_low", int'(tx_ready), 0);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    wait_ready("busy_ready_back");
    check_val("busy_done_count", done_cnt - d0, 1);

    // Reset after the 4th falling edge, then a normal 0xFF
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, 1'b1, 1'b1);
    dev_run(1'b1, 4);
    wait_cyc(10);
    check_val("abort_no_done", done_cnt - d0, 0);
    check_val("abort_no_err", err_cnt - e0, 0);
    send(8'hFF, 1'b1, 1'b1);
    dev_run(1'b1, 0);
    wait_ready("ff_ready_back");
    check_val("ff_done_count", done_cnt - d0, 1);

    // Device never clocks after release
    e0 = err_cnt;
    send(8'h5A, 1'b0, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    exp_res.push_back(1'b0);
    n = 0;
    while (err_cnt == e0 && n < TMO + INH + 200) begin
      @(negedge clk);
      n++;
    end
    check_val("timeout_err_count", err_cnt - e0, 1);
    wait_ready("timeout_ready_back");
`else
    wait_cyc(TMO + 200);
    check_val("hang_busy", int'(busy), 1);
    check_val("hang_no_err", err_cnt - e0, 0);
    check_val("hang_clk_released", int'(ps2_clk_oe), 0);
    check_val("hang_start_held", int'(ps2_dat_oe), 1);
    resetn = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    resetn = 1'b1;
    wait_cyc(3);
    check_val("hang_recover_ready", int'(tx_ready), 1);
`endif

    wait_cyc(10);
    check_val("bits_all_consumed", exp_bits.size(), 0);
    check_val("results_all_consumed", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
